parity_frame_tx: RTL and testbench
==================================

# parity_frame_tx

Serial transmitter for the 3-bit parity-protected word (X, Y, Z plus parity bit P) that the parity checker block consumes. It accepts a parallel data word over a valid/ready handshake and computes the parity bit. It shifts out a framed serial stream: start, data MSB-first (X, Y, Z), parity, stop. It is the sending end of the checker's link and also presents the computed parity in parallel for direct hookup to the combinational checker.

## Interface
- `DATA_W`, 3, data bits per frame; bit DATA_W-1 = X, then Y, bit 0 = Z.
- `CLKS_PER_BIT`, 4, clock cycles each serial bit is held; must be ≥ 1.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in`  in  DATA_W  word to send; sampled only on an accepted handshake.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  block can accept a word; high only in IDLE and never while `rst` is high.
- `tx_out`  out  1  serial line, registered; idles high.
- `par_out`  out  1  parity bit of the last accepted word, registered.
- `busy`  out  1  frame in progress (any state other than IDLE).
- `done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- Handshake: a word is accepted on a rising edge where `in_valid` and `in_ready` are both 1. `data_in` is then latched into the shift register and `par_out` is updated.
- Parity is even by default: `par_out` = XOR of all `data_in` bits, so XOR(data, P) = 0.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY after DATA_W bits of CLKS_PER_BIT cycles each.
  - PARITY → STOP after CLKS_PER_BIT cycles.
  - STOP → IDLE after CLKS_PER_BIT cycles.
- `tx_out` value per state:
  - IDLE: 1.
  - START: 0.
  - DATA: the current data bit, MSB first.
  - PARITY: `par_out`.
  - STOP: 1.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and is $clog2(CLKS_PER_BIT) bits wide, minimum 1.
  - The bit counter counts 0..DATA_W-1 and is $clog2(DATA_W) bits wide, minimum 1.
  - Neither counter wraps past its terminal value; it reloads to 0 on each bit or state change.
- `in_valid` while busy is ignored. The word is not queued, and `data_in` changes mid-frame do not affect the frame.
- Reset at any time, including mid-frame, returns the block to IDLE on the next edge and abandons any partial frame.
- Reset values: `tx_out`=1, `par_out`=0, `busy`=0, `done`=0, `in_ready`=0 while `rst`=1 and 1 on the first cycle after release.

## Timing
- Accept on edge N: `tx_out` goes 0 and `busy` goes 1 after edge N. The start bit is visible from cycle N+1.
- Frame length is (DATA_W+3)·CLKS_PER_BIT cycles; 24 cycles at the defaults.
- `tx_out` has no combinational path from any input.
- On the last STOP cycle the state moves to IDLE. `done`=1 and `in_ready`=1 in that first IDLE cycle, and `busy`=0.
- Back-to-back throughput: a new word may be accepted in the same cycle `done` is high. The next start bit follows immediately, leaving at most one idle-high cycle between frames.
- CLKS_PER_BIT=1 must work: one cycle per bit, 6-cycle frame at DATA_W=3.

## Configuration
- `PARITY_TX_ODD_EN`:
  - Defined: odd parity, `par_out` = ~XOR(`data_in`), so XOR(data, P) = 1.
  - Undefined (default): even parity.
- The macro affects only the parity computation; framing and timing are identical in both modes.

## Test plan
- Defaults, `data_in`=3'b010 accepted: `par_out`=1. `tx_out` sequence is 0,0,1,0,1,1, each held 4 cycles; `done` pulses at cycle 25 after accept.
- `data_in`=3'b000 → P=0; `data_in`=3'b111 → P=1. Rebuilt with `PARITY_TX_ODD_EN`: 3'b000 → P=1, 3'b111 → P=0.
- `in_valid` held high with words 3'b100 then 3'b011: second word accepted in the `done` cycle, with no lost or duplicated bits. Frame 2 sends P=0.
- `in_valid` pulsed with 3'b101 at cycle 10 of a running frame: ignored, `in_ready`=0. The current frame completes unchanged.
- `rst` asserted during the DATA state: next cycle `tx_out`=1, `busy`=0, `par_out`=0. A new word accepted after release transmits correctly.
- CLKS_PER_BIT=1, `data_in`=3'b110: `tx_out` = 0,1,1,0,0,1 on consecutive cycles.

Source files
------------

// File: rtl/parity_frame_tx.sv
//-----------------------------------------------------------------------------
// Module   : parity_frame_tx
// Brief    : Serial transmitter for a parity-protected word. Accepts a word
//            over valid/ready and sends start, data MSB-first, parity, stop.
//            The parity bit is also presented in parallel on par_out.
//            Define PARITY_TX_ODD_EN to build with odd parity (even otherwise).
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module parity_frame_tx #(
    parameter int DATA_W       = 3,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              par_out,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BAUD_W-1:0]   r_baud;
    logic [BAUD_W-1:0]   w_baud_next;
    logic [BIT_W-1:0]    r_bit;
    logic [BIT_W-1:0]    w_bit_next;
    logic [DATA_W-1:0]   r_shift;
    logic [DATA_W-1:0]   w_shift_next;
    logic                r_par;
    logic                w_par_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_done;
    logic                w_done_next;
    logic                w_parity;
    logic                w_accept;
    logic                w_baud_last;

`ifdef PARITY_TX_ODD_EN
    assign w_parity = ~(^data_in);
`else
    assign w_parity = ^data_in;
`endif

    // Ready only while idle, and forced low during reset.
    assign in_ready    = (r_state == S_IDLE) && !rst;
    assign w_accept    = in_valid && in_ready;
    assign w_baud_last = (r_baud == c_baud_last);

    assign tx_out  = r_tx;
    assign par_out = r_par;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_par   <= w_par_next;
            r_tx    <= w_tx_next;
            r_done  <= w_done_next;
        end
    end

    // Next-state logic; tx is derived from the next state so the line
    // changes on the same edge the state does.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_par_next   = r_par;
        w_done_next  = 1'b0;
        w_tx_next    = 1'b1;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_START;
                    w_shift_next = data_in;
                    w_par_next   = w_parity;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_next = '0;
                    if (r_bit == c_bit_last) begin
                        w_state_next = S_PARITY;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next   = r_bit + 1'b1;
                        w_shift_next = r_shift << 1;
                    end
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_state_next = S_IDLE;
                    w_baud_next  = '0;
                    w_done_next  = 1'b1;
                end else begin
                    w_baud_next = r_baud + 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_bit_next   = '0;
            end
        endcase

        unique case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[DATA_W-1];
            S_PARITY: w_tx_next = w_par_next;
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
//-----------------------------------------------------------------------------
// Module   : tb_parity_frame_tx
// Brief    : Self-checking bench for parity_frame_tx at CLKS_PER_BIT=4 and
//            CLKS_PER_BIT=1, against a frame model built from bit counts.
// Revision : 1.0 - initial release
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [2:0] data_a  = 3'b000;
    logic       valid_a = 1'b0;
    logic       ready_a, tx_a, par_a, busy_a, done_a;

    logic [2:0] data_b  = 3'b000;
    logic       valid_b = 1'b0;
    logic       ready_b, tx_b, par_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_a), .in_valid(valid_a),
        .in_ready(ready_a), .tx_out(tx_a), .par_out(par_a),
        .busy(busy_a), .done(done_a)
    );

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_b), .in_valid(valid_b),
        .in_ready(ready_b), .tx_out(tx_b), .par_out(par_b),
        .busy(busy_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Parity from the count of ones: even parity makes the total even.
    function automatic logic model_par(input logic [2:0] d);
        int ones;
        ones = $countones(d);
`ifdef PARITY_TX_ODD_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    // Frame as transmitted, first bit in the MSB position.
    function automatic logic [5:0] model_frame(input logic [2:0] d);
        return {1'b0, d, model_par(d), 1'b1};
    endfunction

    // Send one word on the 4-clock instance; entered and left at a falling
    // edge, leaving off in the done cycle.
    task automatic frame_a(input logic [2:0] d, input bit hold,
                           input logic [2:0] nd, input bit poke);
        logic [5:0] f;
        logic       p;
        f = model_frame(d);
        p = model_par(d);
        chk("a_ready_before", ready_a, 1'b1);
        data_a  = d;
        valid_a = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            chk("a_tx", tx_a, f[5 - k/4]);
            chk("a_busy", busy_a, 1'b1);
            chk("a_ready_busy", ready_a, 1'b0);
            chk("a_done_busy", done_a, 1'b0);
            chk("a_par", par_a, p);
            if (k == 0) begin
                if (hold) data_a = nd;
                else begin
                    valid_a = 1'b0;
                    data_a  = 3'($urandom);
                end
            end
            if (poke && k == 10) begin
                valid_a = 1'b1;
                data_a  = 3'b101;
            end
            if (poke && k == 11) begin
                valid_a = 1'b0;
                data_a  = 3'($urandom);
            end
        end
        @(negedge clk);
        chk("a_done", done_a, 1'b1);
        chk("a_busy_done", busy_a, 1'b0);
        chk("a_ready_done", ready_a, 1'b1);
        chk("a_tx_done", tx_a, 1'b1);
        chk("a_par_done", par_a, p);
    endtask

    task automatic idle_a(input int n);
        valid_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("a_idle_tx", tx_a, 1'b1);
            chk("a_idle_busy", busy_a, 1'b0);
            chk("a_idle_ready", ready_a, 1'b1);
            chk("a_idle_done", done_a, 1'b0);
        end
    endtask

    // Send one word on the 1-clock instance, valid dropped after accept.
    task automatic frame_b(input logic [2:0] d);
        logic [5:0] f;
        f = model_frame(d);
        chk("b_ready_before", ready_b, 1'b1);
        data_b  = d;
        valid_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("b_tx", tx_b, f[5 - k]);
            chk("b_busy", busy_b, 1'b1);
            chk("b_done_busy", done_b, 1'b0);
            if (k == 0) begin
                valid_b = 1'b0;
                data_b  = 3'($urandom);
            end
        end
        @(negedge clk);
        chk("b_done", done_b, 1'b1);
        chk("b_busy_done", busy_b, 1'b0);
        chk("b_ready_done", ready_b, 1'b1);
        chk("b_par", par_b, model_par(d));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] d;
        logic [2:0] nd;
        bit         hold;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx_a, 1'b1);
        chk("rst_par", par_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_ready", ready_a, 1'b0);
        chk("rst_ready_b", ready_b, 1'b0);
        rst = 1'b0;
        #1;
        chk("rel_ready", ready_a, 1'b1);
        chk("rel_ready_b", ready_b, 1'b1);

        // Directed words
        frame_a(3'b010, 1'b0, 3'b000, 1'b0);
        idle_a(2);
        frame_a(3'b000, 1'b0, 3'b000, 1'b0);
        idle_a(1);
        frame_a(3'b111, 1'b0, 3'b000, 1'b0);
        idle_a(1);

        // Valid held high: second word taken in the done cycle
        frame_a(3'b100, 1'b1, 3'b011, 1'b0);
        frame_a(3'b011, 1'b0, 3'b000, 1'b0);
        idle_a(1);

        // Request pulsed mid-frame is ignored
        frame_a(3'b110, 1'b0, 3'b000, 1'b1);
        idle_a(1);

        // Reset during the data bits
        data_a  = 3'b011;
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", busy_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tx", tx_a, 1'b1);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_par", par_a, 1'b0);
        chk("mid_rst_done", done_a, 1'b0);
        chk("mid_rst_ready", ready_a, 1'b0);
        rst = 1'b0;
        #1;
        chk("mid_rel_ready", ready_a, 1'b1);
        frame_a(3'b101, 1'b0, 3'b000, 1'b0);
        idle_a(1);

        // Randomized frames with random gaps and back-to-back holds
        d = 3'($urandom);
        for (int i = 0; i < 8; i++) begin
            hold = 1'($urandom);
            nd   = 3'($urandom);
            frame_a(d, hold, nd, !hold && 1'($urandom));
            if (hold) d = nd;
            else begin
                idle_a(int'($urandom_range(0, 2)));
                d = 3'($urandom);
            end
        end
        idle_a(1);

        // One clock per bit
        frame_b(3'b110);
        for (int i = 0; i < 4; i++) frame_b(3'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
